sw_digits_conv: RTL and testbench

Parametrised switch-to-display-digit converter that replaces the fixed 16-bit zero-extension mapping. It sits between the board slide switches and the 7-segment display driver. It synchronises and debounces the switch bank, then presents the value as packed 4-bit digits in either hexadecimal or BCD mode. Every completed update is flagged with a one-cycle valid pulse.

---
 rtl/sw_digits_pkg.sv | 22 ++
 rtl/sw_debounce.sv | 51 +++++
 rtl/sw_digits_conv.sv | 141 ++++++++++++++
 tb/tb_sw_digits_conv.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_digits_pkg.sv
// Shared types and helpers for the switch-to-digit converter.
// Holds the FSM state encoding and the BCD sizing/adjust functions.
package sw_digits_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

    // Double-dabble correction applied to one BCD nibble before each shift.
    function automatic logic [3:0] bcd_adj3(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

    // ceil(w*log10(2)) + 1 decimal digits, using log10(2) ~= 0.30103.
    function automatic int unsigned bcd_digits(input int unsigned w);
        return (w * 32'd30103 + 32'd99999) / 32'd100000 + 32'd1;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus counter-based debouncer for a switch bank.
// The accepted vector only moves after DEB_CYCLES consecutive stable cycles.
module sw_debounce
    import sw_digits_pkg::*;
#(
    parameter int unsigned W          = 16,
    parameter int unsigned DEB_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_sw,
    output logic [W-1:0] o_deb
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [W-1:0]  r_sync1;
    logic [W-1:0]  r_sync2;
    logic [W-1:0]  r_sync3;
    logic [W-1:0]  r_deb;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_eff;

    // A fresh change in the synchronised vector restarts the stability count.
    assign w_cnt_eff = (r_sync2 != r_sync3) ? '0 : r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
            r_deb   <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (w_cnt_eff == CW'(DEB_CYCLES - 1)) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_eff + 1'b1;
            end
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/sw_digits_conv.sv
// Debounced switch bank presented as packed hex or BCD display digits.
// A conversion runs whenever the debounced value or the mode departs from the last snapshot.
module sw_digits_conv
    import sw_digits_pkg::*;
#(
    parameter int unsigned SW_W       = 16,
    parameter int unsigned N_DIG      = 8,
    parameter int unsigned DEB_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SW_W-1:0]    sw,
    input  logic               bcd_mode,
    output logic [4*N_DIG-1:0] digs,
    output logic               digs_valid,
    output logic               busy,
    output logic               ovf
);

    localparam int unsigned DW      = 4 * N_DIG;
    localparam int unsigned BCD_DIG = bcd_digits(SW_W);
    localparam int unsigned BW      = 4 * BCD_DIG;
    localparam int unsigned HW      = (DW > SW_W) ? DW : SW_W;
    localparam int unsigned XW      = (DW > BW) ? DW : BW;
    localparam int unsigned IW      = $clog2(SW_W + 1);

    conv_state_t       r_state;
    logic              r_pending;
    logic [SW_W-1:0]   r_snap_val;
    logic              r_snap_mode;
    logic [BW-1:0]     r_bcd;
    logic [SW_W-1:0]   r_bin;
    logic [IW-1:0]     r_iter;
    logic [DW-1:0]     r_digs;
    logic              r_digs_valid;
    logic              r_busy;
    logic              r_ovf;

    logic [SW_W-1:0]   w_deb;
    logic              w_trigger;
    logic [BW-1:0]     w_bcd_adj;
    logic [HW-1:0]     w_hex_ext;
    logic [XW-1:0]     w_bcd_ext;
    logic              w_hex_ovf;
    logic              w_bcd_ovf;

    sw_debounce #(
        .W          (SW_W),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .clk   (clk),
        .reset (reset),
        .i_sw  (sw),
        .o_deb (w_deb)
    );

    assign w_trigger = r_pending || (w_deb != r_snap_val) || (bcd_mode != r_snap_mode);

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int unsigned i = 0; i < BCD_DIG; i++) begin
            w_bcd_adj[4*i +: 4] = bcd_adj3(r_bcd[4*i +: 4]);
        end
    end

    // Anything above the low N_DIG digits is overflow in either mode.
    assign w_hex_ext = HW'(r_snap_val);
    assign w_bcd_ext = XW'(r_bcd);
    assign w_hex_ovf = |(w_hex_ext >> DW);
    assign w_bcd_ovf = |(w_bcd_ext >> DW);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pending    <= 1'b1;
            r_snap_val   <= '0;
            r_snap_mode  <= 1'b0;
            r_bcd        <= '0;
            r_bin        <= '0;
            r_iter       <= '0;
            r_digs       <= '0;
            r_digs_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_digs_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    r_snap_val  <= w_deb;
                    r_snap_mode <= bcd_mode;
                    r_pending   <= 1'b0;
                    if (bcd_mode) begin
                        r_bcd   <= '0;
                        r_bin   <= w_deb;
                        r_iter  <= '0;
                        r_state <= SHIFT;
                    end else begin
                        r_state <= DONE;
                    end
                end
                SHIFT: begin
                    r_bcd <= {w_bcd_adj[BW-2:0], r_bin[SW_W-1]};
                    r_bin <= r_bin << 1;
                    if (r_iter == IW'(SW_W - 1)) begin
                        r_state <= DONE;
                    end else begin
                        r_iter <= r_iter + 1'b1;
                    end
                end
                DONE: begin
                    if (!r_snap_mode) begin
                        r_digs <= w_hex_ext[DW-1:0];
                        r_ovf  <= w_hex_ovf;
                    end else if (w_bcd_ovf) begin
                        r_digs <= {DW{1'b1}};
                        r_ovf  <= 1'b1;
                    end else begin
                        r_digs <= w_bcd_ext[DW-1:0];
                        r_ovf  <= 1'b0;
                    end
                    r_digs_valid <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign digs       = r_digs;
    assign digs_valid = r_digs_valid;
    assign busy       = r_busy;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_sw_digits_conv.sv
// Bench for sw_digits_conv: 8-digit and 4-digit instances share the same stimulus,
// results are compared against an arithmetic digit model.
module tb_sw_digits_conv;

    localparam int unsigned SW_W = 16;
    localparam int unsigned DEB  = 4;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic [15:0] sw       = '0;
    logic        bcd_mode = 1'b0;

    logic [31:0] digs;
    logic        digs_valid, busy, ovf;
    logic [15:0] digs4;
    logic        valid4, busy4, ovf4;

    int total   = 0;
    int bad     = 0;
    int n_valid = 0;

    sw_digits_conv #(.SW_W(SW_W), .N_DIG(8), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .reset(reset), .sw(sw), .bcd_mode(bcd_mode),
        .digs(digs), .digs_valid(digs_valid), .busy(busy), .ovf(ovf)
    );

    sw_digits_conv #(.SW_W(SW_W), .N_DIG(4), .DEB_CYCLES(DEB)) dut4 (
        .clk(clk), .reset(reset), .sw(sw), .bcd_mode(bcd_mode),
        .digs(digs4), .digs_valid(valid4), .busy(busy4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (digs_valid) n_valid++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Digit model: repeated division by the radix; {ovf, digits}.
    function automatic logic [32:0] ref_conv(input int unsigned val, input bit mode,
                                             input int unsigned ndig);
        logic [31:0] d = '0;
        int unsigned v = val;
        int unsigned radix = mode ? 10 : 16;
        bit o;
        for (int unsigned i = 0; i < ndig; i++) begin
            d[4*i +: 4] = 4'(v % radix);
            v = v / radix;
        end
        o = (v != 0);
        if (o && mode) begin
            for (int unsigned i = 0; i < ndig; i++) d[4*i +: 4] = 4'hF;
        end
        return {o, d};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input int budget, output int cyc, output bit got);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (digs_valid) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        int cyc;
        bit got;
        reset = 1'b1; sw = '0; bcd_mode = 1'b0;
        tick(3);
        total++;
        if ({digs, digs_valid, busy, ovf} !== 35'd0) begin
            bad++; $display("FAIL reset_state: got %h expected 0", {digs, digs_valid, busy, ovf});
        end
        reset = 1'b0;
        wait_valid(10, cyc, got);
        total++;
        if (cyc !== 3 || !got) begin bad++; $display("FAIL reset_latency: got %0d expected 3", cyc); end
        total++;
        if (digs !== 32'h0 || ovf !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_conv: got digs=%h ovf=%b busy=%b expected 0/0/0", digs, ovf, busy);
        end
    endtask

    task automatic test_hex();
        int cyc;
        bit got;
        sw = 16'hBEEF;
        wait_valid(30, cyc, got);
        total++;
        if (cyc !== 9 || valid4 !== 1'b1) begin bad++; $display("FAIL hex_latency: got %0d expected 9", cyc); end
        total++;
        if (digs !== 32'h0000_BEEF || ovf !== 1'b0) begin
            bad++; $display("FAIL hex_digs: got %h/%b expected 0000beef/0", digs, ovf);
        end
        total++;
        if (digs4 !== 16'hBEEF || ovf4 !== 1'b0) begin
            bad++; $display("FAIL hex_digs4: got %h/%b expected beef/0", digs4, ovf4);
        end
    endtask

    task automatic test_bcd();
        int cyc;
        bit got;
        bcd_mode = 1'b1;
        wait_valid(40, cyc, got);
        total++;
        if (cyc !== 19) begin bad++; $display("FAIL mode_latency: got %0d expected 19", cyc); end
        total++;
        if (digs !== 32'h0004_8879 || ovf !== 1'b0) begin
            bad++; $display("FAIL mode_digs: got %h/%b expected 00048879/0", digs, ovf);
        end
        sw = 16'hFFFF;
        tick(10);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL bcd_busy: got %b expected 1", busy); end
        wait_valid(40, cyc, got);
        total++;
        if (cyc + 10 !== 25) begin bad++; $display("FAIL bcd_latency: got %0d expected 25", cyc + 10); end
        total++;
        if (digs !== 32'h0006_5535 || ovf !== 1'b0) begin
            bad++; $display("FAIL bcd_digs: got %h/%b expected 00065535/0", digs, ovf);
        end
        total++;
        if (digs4 !== 16'hFFFF || ovf4 !== 1'b1) begin
            bad++; $display("FAIL bcd_digs4: got %h/%b expected ffff/1", digs4, ovf4);
        end
    endtask

    task automatic test_glitch();
        int n0;
        int nb = 0;
        tick(1);
        n0 = n_valid;
        sw[0] = ~sw[0];
        tick(2);
        sw[0] = ~sw[0];
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (busy) nb++;
        end
        total++;
        if (n_valid - n0 !== 0) begin bad++; $display("FAIL glitch_valid: got %0d pulses expected 0", n_valid - n0); end
        total++;
        if (nb !== 0) begin bad++; $display("FAIL glitch_busy: got %0d busy cycles expected 0", nb); end
    endtask

    task automatic test_ovf();
        int cyc;
        bit got;
        sw = 16'd12345;
        wait_valid(40, cyc, got);
        total++;
        if (cyc !== 25) begin bad++; $display("FAIL ovf_latency: got %0d expected 25", cyc); end
        total++;
        if (digs4 !== 16'hFFFF || ovf4 !== 1'b1) begin
            bad++; $display("FAIL ovf_12345: got %h/%b expected ffff/1", digs4, ovf4);
        end
        total++;
        if (digs !== 32'h0001_2345 || ovf !== 1'b0) begin
            bad++; $display("FAIL wide_12345: got %h/%b expected 00012345/0", digs, ovf);
        end
        sw = 16'd9999;
        wait_valid(40, cyc, got);
        total++;
        if (digs4 !== 16'h9999 || ovf4 !== 1'b0 || !got) begin
            bad++; $display("FAIL ovf_9999: got %h/%b expected 9999/0", digs4, ovf4);
        end
    endtask

    task automatic test_simul();
        int cyc;
        bit got;
        int n0;
        sw = 16'h1234;
        tick(6);
        bcd_mode = 1'b0;
        n0 = n_valid;
        wait_valid(40, cyc, got);
        total++;
        if (cyc !== 3) begin bad++; $display("FAIL simul_latency: got %0d expected 3", cyc); end
        total++;
        if (digs !== 32'h0000_1234 || digs4 !== 16'h1234 || ovf !== 1'b0) begin
            bad++; $display("FAIL simul_digs: got %h/%h expected 00001234/1234", digs, digs4);
        end
        tick(30);
        total++;
        if (n_valid - n0 !== 1) begin bad++; $display("FAIL simul_count: got %0d pulses expected 1", n_valid - n0); end
    endtask

    task automatic test_random();
        int cyc;
        bit got;
        logic [15:0] v;
        bit m;
        logic [32:0] e8, e4;
        for (int k = 0; k < 10; k++) begin
            m = 1'($urandom_range(0, 1));
            if (m != bcd_mode) begin
                bcd_mode = m;
                wait_valid(40, cyc, got);
                e8 = ref_conv(int'(sw), m, 8);
                total++;
                if (cyc !== (m ? 19 : 3) || digs !== e8[31:0] || ovf !== e8[32]) begin
                    bad++; $display("FAIL rand_mode: cyc=%0d got %h/%b expected %h/%b", cyc, digs, ovf, e8[31:0], e8[32]);
                end
            end
            do begin
                v = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 9999)) : 16'($urandom_range(0, 65535));
            end while (v == sw);
            sw = v;
            wait_valid(60, cyc, got);
            e8 = ref_conv(int'(v), m, 8);
            e4 = ref_conv(int'(v), m, 4);
            total++;
            if (cyc !== (m ? 25 : 9)) begin bad++; $display("FAIL rand_latency: got %0d expected %0d", cyc, m ? 25 : 9); end
            total++;
            if (digs !== e8[31:0] || ovf !== e8[32]) begin
                bad++; $display("FAIL rand_digs8: v=%0d m=%b got %h/%b expected %h/%b", v, m, digs, ovf, e8[31:0], e8[32]);
            end
            total++;
            if (digs4 !== e4[15:0] || ovf4 !== e4[32]) begin
                bad++; $display("FAIL rand_digs4: v=%0d m=%b got %h/%b expected %h/%b", v, m, digs4, ovf4, e4[15:0], e4[32]);
            end
        end
    endtask

    task automatic test_abort();
        int cyc;
        bit got;
        int n0;
        if (!bcd_mode) begin
            bcd_mode = 1'b1;
            wait_valid(40, cyc, got);
        end
        tick(1);
        n0 = n_valid;
        sw = (sw == 16'd1234) ? 16'd1235 : 16'd1234;
        tick(13);
        sw = 16'd42;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy: got %b expected 1", busy); end
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        total++;
        if (n_valid - n0 !== 0) begin bad++; $display("FAIL abort_valid: got %0d pulses expected 0", n_valid - n0); end
        wait_valid(40, cyc, got);
        total++;
        if (cyc !== 19 || digs !== 32'h0 || ovf !== 1'b0) begin
            bad++; $display("FAIL abort_forced: cyc=%0d got %h expected 19/00000000", cyc, digs);
        end
        wait_valid(60, cyc, got);
        total++;
        if (!got || digs !== 32'h0000_0042 || digs4 !== 16'h0042 || ovf !== 1'b0) begin
            bad++; $display("FAIL abort_final: got %h/%h expected 00000042/0042", digs, digs4);
        end
    endtask

    initial begin
        test_reset();
        test_hex();
        test_bcd();
        test_glitch();
        test_ovf();
        test_simul();
        test_random();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
